// File: rtl/seyahat_dogrula.sv
// -----------------------------------------------------------------------------
// seyahat_dogrula -- travel validator
//
// Declares a trip valid when the 6-bit route code is one of four legal routes
// and the 4-bit fuel level is at or above YAKIT_ESIK. The three verdict
// outputs are purely combinational. A clocked shadow stage registers the
// verdict and counts the cycles with a valid verdict. That count saturates
// instead of wrapping.
//
// Parameters
//   YAKIT_ESIK       minimum fuel level for travel (yakit >= YAKIT_ESIK)
//   SAYAC_W          width of the valid-cycle counter
//
// Ports
//   clk              in   1        system clock, rising edge
//   rst_n            in   1        asynchronous, active-low reset
//   yakit            in   4        fuel level, unsigned 0..15
//   rota             in   6        route code
//   seyahat_dogru    out  1        rota_dogru & yakit_yeterli (combinational)
//   rota_dogru       out  1        route code is legal (combinational)
//   yakit_yeterli    out  1        yakit >= YAKIT_ESIK (combinational)
//   seyahat_dogru_q  out  1        seyahat_dogru registered on clk
//   gecerli_sayac    out  SAYAC_W  saturating count of cycles with a valid trip
// -----------------------------------------------------------------------------
module seyahat_dogrula #(
    parameter int unsigned YAKIT_ESIK = 12,
    parameter int unsigned SAYAC_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         yakit,
    input  logic [5:0]         rota,
    output logic               seyahat_dogru,
    output logic               rota_dogru,
    output logic               yakit_yeterli,
    output logic               seyahat_dogru_q,
    output logic [SAYAC_W-1:0] gecerli_sayac
);

    // The comparison is done at 5 bits so that a threshold of 16
    // correctly means that no fuel level is enough.
    localparam logic [4:0]         ESIK_W    = 5'(YAKIT_ESIK);
    localparam logic [SAYAC_W-1:0] SAYAC_MAX = {SAYAC_W{1'b1}};

    logic               karar_q, karar_d;
    logic [SAYAC_W-1:0] sayac_q, sayac_d;

    // ---------------------------------------------------------------------
    // Combinational decision path. It does not depend on clk or rst_n, so
    // it stays valid while reset is held.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default first means every path drives the output,
        // so no latch is inferred for route codes that are not listed.
        rota_dogru = 1'b0;
        unique case (rota)
            6'b111000,
            6'b100011,
            6'b100101,
            6'b100110: rota_dogru = 1'b1;
            default:   rota_dogru = 1'b0;
        endcase
    end

    assign yakit_yeterli = ({1'b0, yakit} >= ESIK_W);
    assign seyahat_dogru = rota_dogru & yakit_yeterli;

    // ---------------------------------------------------------------------
    // Shadow stage: registered verdict plus a saturating valid-cycle count.
    // ---------------------------------------------------------------------
    always_comb begin
        karar_d = seyahat_dogru;
        sayac_d = sayac_q;
        if (seyahat_dogru && (sayac_q != SAYAC_MAX)) begin
            sayac_d = sayac_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            karar_q <= 1'b0;
            sayac_q <= '0;
        end else begin
            // NOTE: use non-blocking assignments for state, so that every flop
            // samples values from before the edge, whatever the statement order.
            karar_q <= karar_d;
            sayac_q <= sayac_d;
        end
    end

    assign seyahat_dogru_q = karar_q;
    assign gecerli_sayac   = sayac_q;

endmodule

// File: tb/tb_seyahat_dogrula.sv
// -----------------------------------------------------------------------------
// tb_seyahat_dogrula -- self-checking bench for seyahat_dogrula
//
// The reference model lists the legal routes and the fuel threshold from the
// travel rules. It keeps the expected registered verdict and the expected
// saturating count as plain integers.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_seyahat_dogrula;

    localparam int ESIK  = 12;
    localparam int CMAX  = 255;

    logic       clk;
    logic       rst_n;
    logic [3:0] yakit;
    logic [5:0] rota;
    logic       seyahat_dogru, rota_dogru, yakit_yeterli, seyahat_dogru_q;
    logic [7:0] gecerli_sayac;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state for the registered path.
    bit exp_q   = 1'b0;
    int exp_cnt = 0;

    logic [5:0] legal_routes [4] = '{6'b111000, 6'b100011, 6'b100101, 6'b100110};

    seyahat_dogrula #(.YAKIT_ESIK(12), .SAYAC_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .yakit           (yakit),
        .rota            (rota),
        .seyahat_dogru   (seyahat_dogru),
        .rota_dogru      (rota_dogru),
        .yakit_yeterli   (yakit_yeterli),
        .seyahat_dogru_q (seyahat_dogru_q),
        .gecerli_sayac   (gecerli_sayac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_route(input logic [5:0] r);
        foreach (legal_routes[i]) if (legal_routes[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_fuel(input logic [3:0] y);
        return int'(y) >= ESIK;
    endfunction

    // One rising edge. Update the model from the inputs that were present
    // before the edge, then wait #1 so that sampling is away from the edge.
    task automatic tick();
        bit v;
        v = ref_route(rota) && ref_fuel(yakit);
        @(posedge clk);
        #1;
        if (rst_n) begin
            exp_q = v;
            if (v && exp_cnt < CMAX) exp_cnt++;
        end
    endtask

    task automatic check_regs(input string name);
        tests_run++;
        if (seyahat_dogru_q !== exp_q) begin
            tests_failed++;
            $display("FAIL %s seyahat_dogru_q got %b expected %b", name, seyahat_dogru_q, exp_q);
        end
        tests_run++;
        if (gecerli_sayac !== 8'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL %s gecerli_sayac got %0d expected %0d", name, gecerli_sayac, exp_cnt);
        end
    endtask

    task automatic check_comb(input string name);
        bit er, ey;
        er = ref_route(rota);
        ey = ref_fuel(yakit);
        tests_run++;
        if (rota_dogru !== er || yakit_yeterli !== ey || seyahat_dogru !== (er && ey)) begin
            tests_failed++;
            $display("FAIL %s rota=%b yakit=%0d got r/y/s=%b%b%b expected %b%b%b",
                     name, rota, yakit, rota_dogru, yakit_yeterli, seyahat_dogru,
                     er, ey, er && ey);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rota  = 6'b000000;
        yakit = 4'd0;
        exp_q = 1'b0;
        exp_cnt = 0;
        #1;
        check_regs("reset_async");
        // The registers must stay cleared across edges while reset is held.
        rota = 6'b111000;
        yakit = 4'd15;
        tick();
        tick();
        check_regs("reset_held");
    endtask

    // All 1024 input combinations, with reset still asserted. The decision
    // outputs must be valid during reset.
    task automatic test_exhaustive();
        for (int r = 0; r < 64; r++) begin
            for (int y = 0; y < 16; y++) begin
                rota  = 6'(r);
                yakit = 4'(y);
                #0.1;
                check_comb("exhaustive");
            end
        end
    endtask

    task automatic expect_outs(input string name, input logic [5:0] r, input logic [3:0] y,
                               input bit es, input bit er, input bit ey);
        rota  = r;
        yakit = y;
        #0.1;
        tests_run++;
        if (seyahat_dogru !== es || rota_dogru !== er || yakit_yeterli !== ey) begin
            tests_failed++;
            $display("FAIL %s got s/r/y=%b%b%b expected %b%b%b", name,
                     seyahat_dogru, rota_dogru, yakit_yeterli, es, er, ey);
        end
    endtask

    task automatic test_directed();
        expect_outs("dir_111000_y12", 6'b111000, 4'd12, 1, 1, 1);
        expect_outs("dir_111000_y11", 6'b111000, 4'd11, 0, 1, 0);
        expect_outs("dir_100110_y15", 6'b100110, 4'd15, 1, 1, 1);
        expect_outs("dir_100111_y15", 6'b100111, 4'd15, 0, 0, 1);
        expect_outs("dir_000000_y15", 6'b000000, 4'd15, 0, 0, 1);
        expect_outs("dir_100101_y0",  6'b100101, 4'd0,  0, 1, 0);
    endtask

    task automatic test_counting();
        rota  = 6'b100011;
        yakit = 4'd13;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_regs("count_first_edge");
        for (int i = 0; i < 4; i++) tick();
        check_regs("count_five");
        tests_run++;
        if (gecerli_sayac !== 8'd5) begin
            tests_failed++;
            $display("FAIL count_five_abs gecerli_sayac got %0d expected 5", gecerli_sayac);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1, 0) == 1) rota = legal_routes[$urandom_range(3, 0)];
            else                            rota = 6'($urandom);
            yakit = 4'($urandom);
            #0.1;
            check_comb("random_comb");
            tick();
            check_regs("random_regs");
        end
    endtask

    task automatic test_saturation();
        rota  = 6'b100101;
        yakit = 4'd14;
        for (int i = 0; i < 300; i++) tick();
        check_regs("saturation");
        tests_run++;
        if (gecerli_sayac !== 8'd255) begin
            tests_failed++;
            $display("FAIL saturation_abs gecerli_sayac got %0d expected 255", gecerli_sayac);
        end
    endtask

    task automatic test_async_reset();
        // Assert reset midway between edges. No clock edge occurs before the check.
        #2;
        rst_n = 1'b0;
        exp_q = 1'b0;
        exp_cnt = 0;
        #1;
        check_regs("async_pulse");
        #1;
        rst_n = 1'b1;
        tick();
        check_regs("resume_after_reset");
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_directed();
        test_counting();
        test_random();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
